// File: rtl/seven_seg_pkg.sv
// Shared constants for the registered hex to seven-segment decoder.
// Segment vectors are active-high, bit 6 = a down to bit 0 = g.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b000_0000;

  // Codes at or above this are letters and count as invalid without hex.
  localparam logic [3:0] HEX_LIMIT = 4'd10;

  localparam logic [0:15][SEG_W-1:0] SEG_TABLE = '{
    7'b111_1110,
    7'b011_0000,
    7'b110_1101,
    7'b111_1001,
    7'b011_0011,
    7'b101_1011,
    7'b101_1111,
    7'b111_0000,
    7'b111_1111,
    7'b111_1011,
    7'b111_0111,
    7'b001_1111,
    7'b100_1110,
    7'b011_1101,
    7'b100_1111,
    7'b100_0111
  };

endpackage

// File: rtl/seven_seg_inv_if.sv
// Nibble input and segment/decimal-point output bundle.
// The decoder is the slave; the nibble source is the master.
interface seven_seg_inv_if;

  logic a;
  logic b;
  logic c;
  logic d;

  logic oa;
  logic ob;
  logic oc;
  logic od;
  logic oe;
  logic of;
  logic og;
  logic odp;

  modport master (
    output a, b, c, d,
    input  oa, ob, oc, od, oe, of, og, odp
  );

  modport slave (
    input  a, b, c, d,
    output oa, ob, oc, od, oe, of, og, odp
  );

endinterface

// File: rtl/seven_seg_rom.sv
// Combinational nibble to active-high segment lookup.
// valid is low for the letter codes 10..15.
module seven_seg_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg,
  output logic       valid
);

  always_comb begin
    seg   = SEG_TABLE[code];
    valid = (code < HEX_LIMIT);
  end

endmodule

// File: rtl/seven_seg_inv.sv
// Registered hex to seven-segment decoder with selectable polarity.
// Outputs come straight from flops so the pins never glitch.
module seven_seg_inv
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_inv_if.slave  bus
);

  localparam logic [7:0] OUT_OFF = {8{ACTIVE_LOW}};

  logic [3:0] code;
  seg_t       rom_seg;
  logic       rom_valid;
  seg_t       seg_hi;
  logic       dp_hi;

  logic [7:0] out_d;
  logic [7:0] out_q;

  assign code = {bus.a, bus.b, bus.c, bus.d};

  seven_seg_rom u_rom (
    .code  (code),
    .seg   (rom_seg),
    .valid (rom_valid)
  );

  always_comb begin
    seg_hi = rom_seg;
    dp_hi  = 1'b0;
    if (!HEX_EN && !rom_valid) begin
      seg_hi = SEG_BLANK;
      dp_hi  = 1'b1;
    end
    // Polarity is applied once, just ahead of the output register.
    out_d = {seg_hi, dp_hi} ^ OUT_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= OUT_OFF;
    else        out_q <= out_d;
  end

  assign bus.oa  = out_q[7];
  assign bus.ob  = out_q[6];
  assign bus.oc  = out_q[5];
  assign bus.od  = out_q[4];
  assign bus.oe  = out_q[3];
  assign bus.of  = out_q[2];
  assign bus.og  = out_q[1];
  assign bus.odp = out_q[0];

endmodule

// File: tb/tb_seven_seg_inv.sv
// Bench for seven_seg_inv: three parameter variants share one nibble.
// Expected values come from a letter-list model of the segment table.
module tb_seven_seg_inv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seven_seg_inv_if if_s ();
  seven_seg_inv_if if_n ();
  seven_seg_inv_if if_h ();

  seven_seg_inv #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s.slave)
  );

  seven_seg_inv #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_n.slave)
  );

  seven_seg_inv #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dut_h (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_h.slave)
  );

  wire [7:0] o_s = {if_s.oa, if_s.ob, if_s.oc, if_s.od,
                    if_s.oe, if_s.of, if_s.og, if_s.odp};
  wire [7:0] o_n = {if_n.oa, if_n.ob, if_n.oc, if_n.od,
                    if_n.oe, if_n.of, if_n.og, if_n.odp};
  wire [7:0] o_h = {if_h.oa, if_h.ob, if_h.oc, if_h.od,
                    if_h.oe, if_h.of, if_h.og, if_h.odp};

  int tests = 0;
  int fails = 0;

  string lit [16] = '{
    "abcdef", "bc", "abdeg", "abcdg",
    "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg",
    "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic bit has(string s, byte ch);
    for (int i = 0; i < s.len(); i++)
      if (s[i] == ch) return 1'b1;
    return 1'b0;
  endfunction

  // Returns {a..g, dp} as driven on the pins.
  function automatic logic [7:0] model(int n, bit al, bit hx);
    logic [7:0] r;
    string names;
    bit on;
    names = "abcdefg";
    for (int i = 0; i < 7; i++) begin
      on = (hx || n < 10) && has(lit[n], names[i]);
      r[7-i] = on ^ al;
    end
    r[0] = (!hx && n >= 10) ^ al;
    return r;
  endfunction

  task automatic drive(int n);
    logic [3:0] v;
    v = n[3:0];
    {if_s.a, if_s.b, if_s.c, if_s.d} = v;
    {if_n.a, if_n.b, if_n.c, if_n.d} = v;
    {if_h.a, if_h.b, if_h.c, if_h.d} = v;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_all(int n, string tag);
    chk({tag, "_std"}, o_s, model(n, 1'b1, 1'b1));
    chk({tag, "_nohex"}, o_n, model(n, 1'b1, 1'b0));
    chk({tag, "_ahigh"}, o_h, model(n, 1'b0, 1'b1));
  endtask

  task automatic check_blank(string tag);
    chk({tag, "_std"}, o_s, 8'hFF);
    chk({tag, "_nohex"}, o_n, 8'hFF);
    chk({tag, "_ahigh"}, o_h, 8'h00);
  endtask

  task automatic step(int n, string tag);
    @(negedge clk);
    drive(n);
    @(posedge clk);
    #1;
    check_all(n, tag);
  endtask

  initial begin
    drive(8);
    repeat (3) @(posedge clk);
    #1;
    check_blank("reset");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all(8, "release");
    chk("release_lit8", o_s, 8'b0000_0001);

    // Exhaustive sweep, also checking mid-cycle input changes are ignored.
    for (int n = 0; n < 16; n++) begin
      step(n, "sweep");
      drive(15 - n);
      #2;
      check_all(n, "hold");
    end

    // Binary counting: every code appears in order, one per cycle.
    for (int k = 0; k < 32; k++)
      step(k % 16, "count");

    step(9, "nohex9");
    chk("nohex9_pins", o_n, 8'b0000_1001);
    step(12, "nohex12");
    chk("nohex12_pins", o_n, 8'b1111_1110);
    step(1, "ahigh1");
    chk("ahigh1_pins", o_h, 8'b0110_0000);
    step(15, "std15");
    chk("std15_pins", o_s, 8'b0111_0001);

    for (int k = 0; k < 60; k++)
      step(int'($urandom_range(0, 15)), "rand");

    // Asynchronous reset between edges.
    step(2, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_blank("async_rst");
    @(posedge clk);
    #1;
    check_blank("rst_held");

    @(negedge clk);
    rst_n = 1'b1;
    drive(5);
    @(posedge clk);
    #1;
    check_all(5, "rerelease");

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_blank("ahigh_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
